// File: rtl/pipeline_stage_register_if.sv
// ============================================================================
// Module      : pipeline_stage_register_if
// Description : Valid/ready beat bus with a data and a control payload.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_stage_register_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input  ready);
  modport slave  (input  valid, input  data, input  ctrl, output ready);
endinterface

`default_nettype wire

// File: rtl/pipeline_stage_register.sv
// ============================================================================
// Module      : pipeline_stage_register
// Description : Inter-stage pipeline register with a 2-entry skid buffer,
//               synchronous flush and bubble-masked control payload.
//               Optional stall counter enabled by PIPE_STAGE_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_stage_register #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  wire logic                 clk,
  input  wire logic                 reset_n,
  input  wire logic                 flush,
  pipeline_stage_register_if.slave  in_if,
  pipeline_stage_register_if.master out_if
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]      stall_count
`endif
);

  // State encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
  localparam logic [1:0] S_EMPTY = 2'b00;
  localparam logic [1:0] S_FULL  = 2'b10;
  localparam logic [1:0] S_SKID  = 2'b11;

  logic [1:0]            state_q,     state_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;

  logic main_valid;
  logic skid_valid;
  logic accept;
  logic pop;

  assign main_valid = state_q[1];
  assign skid_valid = state_q[0];
  assign accept     = in_if.valid & ~skid_valid;
  assign pop        = main_valid & out_if.ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    // Flush drops every held beat and any beat offered this cycle; the
    // payload registers keep stale contents, hidden by the ctrl mask.
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d     = S_FULL;
            main_data_d = in_if.data;
            main_ctrl_d = in_if.ctrl;
          end
        end
        S_FULL: begin
          if (accept && pop) begin
            main_data_d = in_if.data;
            main_ctrl_d = in_if.ctrl;
          end else if (accept) begin
            state_d     = S_SKID;
            skid_data_d = in_if.data;
            skid_ctrl_d = in_if.ctrl;
          end else if (pop) begin
            state_d = S_EMPTY;
          end
        end
        S_SKID: begin
          if (pop) begin
            state_d     = S_FULL;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // in_ready depends only on registered state, never on out_ready.
  always_comb begin
    in_if.ready  = ~skid_valid;
    out_if.valid = main_valid;
    out_if.data  = main_data_q;
    out_if.ctrl  = main_valid ? main_ctrl_q : '0;
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (main_valid && !out_if.ready && !(&stall_count_q)) begin
      stall_count_d = stall_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`else
  // Counter is not built; CNT_WIDTH is only meaningful with the counter.
  if (CNT_WIDTH > 0) begin : g_no_stall_cnt
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stage_register.sv
// ============================================================================
// Module      : tb_pipeline_stage_register
// Description : Directed, table-driven self-checking bench for the stage reg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_stage_register;

  localparam int DW    = 32;
  localparam int CW    = 8;
  localparam int CNT_W = 4;
  localparam int NV    = 19;

  logic clk;
  logic reset_n;
  logic flush;

  pipeline_stage_register_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) up_if ();
  pipeline_stage_register_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dn_if ();

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_count;
`endif

  pipeline_stage_register #(
    .DATA_WIDTH (DW),
    .CTRL_WIDTH (CW),
    .CNT_WIDTH  (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_if       (up_if),
    .out_if      (dn_if)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;
    logic          flush;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic [CW-1:0] exp_ctrl;
    logic          exp_ready;
  } vec_t;

  vec_t vecs [NV];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic iv, input logic [DW-1:0] id,
                              input logic [CW-1:0] ic, input logic ordy,
                              input logic fl, input logic ev,
                              input logic [DW-1:0] ed, input logic [CW-1:0] ec,
                              input logic er);
    vec_t v;
    v.in_valid = iv; v.in_data = id; v.in_ctrl = ic; v.out_ready = ordy;
    v.flush = fl; v.exp_valid = ev; v.exp_data = ed; v.exp_ctrl = ec;
    v.exp_ready = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [DW-1:0] id,
                       input logic [CW-1:0] ic, input logic ordy,
                       input logic fl);
    up_if.valid = iv;
    up_if.data  = id;
    up_if.ctrl  = ic;
    dn_if.ready = ordy;
    flush       = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ev,
                         input logic [DW-1:0] ed, input logic [CW-1:0] ec,
                         input logic er);
    chk({tag, ".out_valid"}, 32'(dn_if.valid), 32'(ev));
    chk({tag, ".out_data"},  32'(dn_if.data),  32'(ed));
    chk({tag, ".out_ctrl"},  32'(dn_if.ctrl),  32'(ec));
    chk({tag, ".in_ready"},  32'(up_if.ready), 32'(er));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Expected values: state after the edge that applies each row.
    // basic flow, out_ready high
    vecs[0]  = mk(1'b1, 32'h10, 8'h81, 1'b1, 1'b0, 1'b1, 32'h10, 8'h81, 1'b1);
    vecs[1]  = mk(1'b1, 32'h20, 8'h81, 1'b1, 1'b0, 1'b1, 32'h20, 8'h81, 1'b1);
    vecs[2]  = mk(1'b1, 32'h30, 8'h81, 1'b1, 1'b0, 1'b1, 32'h30, 8'h81, 1'b1);
    vecs[3]  = mk(1'b0, 32'h0,  8'h00, 1'b1, 1'b0, 1'b0, 32'h30, 8'h00, 1'b1);
    // back-pressure into SKID, C held then released in order
    vecs[4]  = mk(1'b1, 32'hA,  8'h01, 1'b0, 1'b0, 1'b1, 32'hA,  8'h01, 1'b1);
    vecs[5]  = mk(1'b1, 32'hB,  8'h02, 1'b0, 1'b0, 1'b1, 32'hA,  8'h01, 1'b0);
    vecs[6]  = mk(1'b1, 32'hC,  8'h03, 1'b0, 1'b0, 1'b1, 32'hA,  8'h01, 1'b0);
    vecs[7]  = mk(1'b1, 32'hC,  8'h03, 1'b1, 1'b0, 1'b1, 32'hB,  8'h02, 1'b1);
    vecs[8]  = mk(1'b1, 32'hC,  8'h03, 1'b1, 1'b0, 1'b1, 32'hC,  8'h03, 1'b1);
    vecs[9]  = mk(1'b0, 32'h0,  8'h00, 1'b1, 1'b0, 1'b0, 32'hC,  8'h00, 1'b1);
    // flush with skid full and D offered on the same edge
    vecs[10] = mk(1'b1, 32'hE,  8'h04, 1'b0, 1'b0, 1'b1, 32'hE,  8'h04, 1'b1);
    vecs[11] = mk(1'b1, 32'hF,  8'h05, 1'b0, 1'b0, 1'b1, 32'hE,  8'h04, 1'b0);
    vecs[12] = mk(1'b1, 32'hD,  8'h06, 1'b0, 1'b1, 1'b0, 32'hE,  8'h00, 1'b1);
    vecs[13] = mk(1'b0, 32'h0,  8'h00, 1'b1, 1'b0, 1'b0, 32'hE,  8'h00, 1'b1);
    // bubble masking with ctrl=FF
    vecs[14] = mk(1'b1, 32'h55, 8'hFF, 1'b1, 1'b0, 1'b1, 32'h55, 8'hFF, 1'b1);
    vecs[15] = mk(1'b0, 32'h0,  8'h00, 1'b1, 1'b0, 1'b0, 32'h55, 8'h00, 1'b1);
    vecs[16] = mk(1'b0, 32'h0,  8'h00, 1'b0, 1'b0, 1'b0, 32'h55, 8'h00, 1'b1);
    // flush beats simultaneous accept and pop in FULL
    vecs[17] = mk(1'b1, 32'h66, 8'h07, 1'b1, 1'b0, 1'b1, 32'h66, 8'h07, 1'b1);
    vecs[18] = mk(1'b1, 32'h77, 8'h08, 1'b1, 1'b1, 1'b0, 32'h66, 8'h00, 1'b1);

    reset_n = 1'b0;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    #2;
    chk_out("reset", 1'b0, 32'h0, 8'h00, 1'b1);
`ifdef PIPE_STAGE_STALL_CNT_EN
    chk("reset.stall_count", 32'(stall_count), 32'h0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].in_valid, vecs[i].in_data, vecs[i].in_ctrl,
            vecs[i].out_ready, vecs[i].flush);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
              vecs[i].exp_ctrl, vecs[i].exp_ready);
    end

    // Asynchronous reset asserted between edges while in SKID.
    drive(1'b1, 32'hA1, 8'h11, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hB1, 8'h12, 1'b0, 1'b0);
    step();
    chk("skid_before_reset.in_ready", 32'(up_if.ready), 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("async_reset", 1'b0, 32'h0, 8'h00, 1'b1);
`ifdef PIPE_STAGE_STALL_CNT_EN
    chk("async_reset.stall_count", 32'(stall_count), 32'h0);
`endif
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 32'hC1, 8'h13, 1'b1, 1'b0);
    step();
    chk_out("after_reset", 1'b1, 32'hC1, 8'h13, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    chk_out("after_reset_drain", 1'b0, 32'hC1, 8'h00, 1'b1);

`ifdef PIPE_STAGE_STALL_CNT_EN
    // Stall counter: one beat held under back-pressure, then flushed.
    chk("stall.start", 32'(stall_count), 32'h0);
    drive(1'b1, 32'h99, 8'h21, 1'b0, 1'b0);
    step();
    chk("stall.accept_edge", 32'(stall_count), 32'h0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (5) step();
    chk("stall.after5", 32'(stall_count), 32'd5);
    repeat (15) step();
    chk("stall.saturated", 32'(stall_count), 32'd15);
    step();
    chk("stall.held", 32'(stall_count), 32'd15);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("stall.after_flush", 32'(stall_count), 32'd15);
    chk("stall.flush_valid", 32'(dn_if.valid), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipeline_stage_register.md
Name: pipeline_stage_register

Overview:
- Generic, parametrised inter-stage pipeline register for the CPU pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces the fixed-field, wren-gated stage registers with a single block that has:
  - a valid/ready handshake;
  - a 2-entry skid buffer, so back-pressure does not cost throughput;
  - synchronous flush for bubble insertion.
- Payload is split into a data field (passed through) and a control field (forced to zero whenever the output is not valid). A bubble can therefore never assert reg_wren, ram_wren or similar downstream.

Parameters:
- DATA_WIDTH, 32, width of the data payload (pc, alu results, addresses concatenated by the instantiating stage).
- CTRL_WIDTH, 8, width of the control payload (write enables, mux selects); masked to 0 on bubbles.
- CNT_WIDTH, 32, width of the stall counter (used only with the optional feature).

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream has a valid beat.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  DATA_WIDTH  upstream data payload.
- in_ctrl  in  CTRL_WIDTH  upstream control payload.
- out_valid  out  1  out_data/out_ctrl hold a valid beat.
- out_ready  in  1  downstream consumes the beat this cycle.
- out_data  out  DATA_WIDTH  data payload of the head entry.
- out_ctrl  out  CTRL_WIDTH  control of the head entry; all zeros when out_valid=0.
- stall_count  out  CNT_WIDTH  present only with PIPE_STAGE_STALL_CNT_EN.

Behaviour:
- Storage and outputs:
  - Storage is a main entry (drives the outputs) and a skid entry, each with a valid bit.
  - in_ready = !skid_valid. It comes from a register, with no combinational path from out_ready.
  - out_valid = main_valid. out_data = main_data.
  - out_ctrl = main_valid ? main_ctrl : 0.
- Handshake:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - A beat is transferred only on those conditions.
  - in_data/in_ctrl are ignored when accept=0.
- States (derived from the valid bits):
  - EMPTY (main=0, skid=0), FULL (main=1, skid=0), SKID (main=1, skid=1).
  - main=0 with skid=1 is unreachable.
- Transitions, absent flush:
  - EMPTY:
    - accept -> FULL, main <= in.
  - FULL:
    - accept & pop -> FULL, main <= in.
    - accept & !pop -> SKID, skid <= in.
    - !accept & pop -> EMPTY.
    - Otherwise hold.
  - SKID (in_ready=0):
    - pop -> FULL, main <= skid, skid_valid <= 0.
    - Otherwise hold.
- Ordering and timing:
  - Beats leave in arrival order. No beat is dropped or duplicated.
  - Latency is 1 cycle: a beat accepted at edge N appears on out_valid after edge N.
  - Throughput is 1 beat/cycle when out_ready is held high.
- flush:
  - On the next edge: main_valid <= 0, skid_valid <= 0 (-> EMPTY).
  - flush overrides a simultaneous accept (that beat is discarded) and a simultaneous pop.
  - Data registers keep their stale contents; out_ctrl reads 0 because of the mask.
  - in_ready = 1 the cycle after flush.
- Reset (asynchronous, reset_n=0):
  - Both valid bits, all data/ctrl registers and the counter go to 0 immediately.
  - Outputs: out_valid=0, out_data=0, out_ctrl=0, in_ready=1, stall_count=0.
  - A reset asserted mid-transfer discards all held beats.
  - After release, the first edge behaves as EMPTY.
- Simultaneous events: flush > pop/accept. Reset dominates everything.

Optional Feature:
- Macro: PIPE_STAGE_STALL_CNT_EN.
- Defined:
  - Port stall_count exists.
  - It increments by 1 on every edge where out_valid=1 and out_ready=0.
  - It saturates at all ones, with no wrap.
  - It is unaffected by flush and cleared only by reset.
- Undefined: the port and counter logic are absent; the remaining behaviour is identical.

Test Plan:
- Reset → basic flow: with out_ready=1, send beats data=0x00000010, 0x00000020, 0x00000030 (ctrl=0x81) on consecutive cycles. Each appears 1 cycle later, back-to-back. in_ready stays 1.
- Back-pressure/skid: out_ready=0, send 0xA and 0xB. After 2 edges: out_data=0xA, in_ready=0 (SKID). A third beat 0xC held on in_valid is not accepted. Raise out_ready: output sequence is 0xA, 0xB, 0xC.
- Flush with skid full, plus in_valid=1 (0xD) on the same cycle: next cycle out_valid=0, out_ctrl=0x00, in_ready=1. 0xD never appears.
- Bubble masking: hold in_valid=0 after one beat with ctrl=0xFF is popped. out_valid=0 and out_ctrl=0x00, while out_data still shows the old value.
- Async reset mid-SKID: drop reset_n between edges. Outputs clear immediately: out_valid=0, in_ready=1. With the macro, stall_count=0.
- Macro defined, CNT_WIDTH=4: hold out_valid=1, out_ready=0 for 20 cycles. stall_count reaches 15 and stays 15. A later flush leaves it at 15.
